// File: rtl/sprite_line_renderer.sv
// Single-sprite scanline engine: fetches one bitmap row from a sync ROM in hblank, then serialises it
// as 1-bit gfx at sprite_x (flip/mirror/2x scale); gfx/active lag hpos by one clock, no backpressure.
module sprite_line_renderer #(
    parameter int W         = 8,
    parameter int H         = 16,
    parameter int AW        = 4,
    parameter int LOAD_HPOS = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    hpos,
    input  logic [8:0]    vpos,
    input  logic          display_on,
    input  logic          enable,
    input  logic [8:0]    sprite_x,
    input  logic [8:0]    sprite_y,
    input  logic          hflip,
    input  logic          vflip,
    input  logic          mirror,
    input  logic          scale,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_data,
    output logic          gfx,
    output logic          active
);
    localparam int PCW = $clog2(4 * W) + 1;
    localparam int IW  = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, FETCH, LATCH, ARMED, DRAW} state_t;

    state_t         state_q;
    logic [W-1:0]   row_q;
    logic [8:0]     x_q;
    logic           mirror_q;
    logic           scale_q;
    logic [PCW-1:0] pc_q;
    logic           rom_rd_q;
    logic [AW-1:0]  rom_addr_q;
    logic           gfx_q;
    logic           active_q;

    logic [8:0]     line_y;
    logic [8:0]     dy;
    logic           in_range;
    logic [8:0]     r;
    logic [AW-1:0]  fetch_addr;
    logic [W-1:0]   row_d;
    logic           at_load;
    logic           at_start;
    logic [PCW-1:0] cur_pc;
    logic [PCW-1:0] p;
    logic [PCW-1:0] bit_idx;
    logic [PCW-1:0] ew_last;
    logic           pix;

    // Row selection for the line after the current one; dy is modular so sprites wrap past line 511.
    always_comb begin
        line_y     = vpos + 9'd1;
        dy         = line_y - sprite_y;
        in_range   = scale ? ({1'b0, dy} < 10'(2 * H)) : ({1'b0, dy} < 10'(H));
        r          = scale ? {1'b0, dy[8:1]} : dy;
        fetch_addr = vflip ? AW'(H - 1) - AW'(r) : AW'(r);
        row_d      = rom_data;
        for (int i = 0; i < W; i++) begin
            row_d[i] = hflip ? rom_data[W-1-i] : rom_data[i];
        end
    end

    // Pixel 0 is emitted on the ARMED->DRAW edge so gfx trails the matching hpos by one clock.
    always_comb begin
        at_load  = (hpos == 9'(LOAD_HPOS));
        at_start = (hpos == x_q) && ({1'b0, x_q} < 10'(LOAD_HPOS));
        cur_pc   = (state_q == DRAW) ? pc_q : '0;
        p        = scale_q ? (cur_pc >> 1) : cur_pc;
        bit_idx  = (p < PCW'(W)) ? PCW'(W - 1) - p : p - PCW'(W);
        pix      = row_q[IW'(bit_idx)];
        case ({mirror_q, scale_q})
            2'b00:   ew_last = PCW'(W - 1);
            2'b11:   ew_last = PCW'(4 * W - 1);
            default: ew_last = PCW'(2 * W - 1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            x_q        <= '0;
            mirror_q   <= 1'b0;
            scale_q    <= 1'b0;
            pc_q       <= '0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            gfx_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            rom_rd_q <= 1'b0;
            gfx_q    <= 1'b0;
            active_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (at_load) state_q <= CHECK;
                end
                CHECK: begin
                    if (enable && in_range) begin
                        state_q    <= FETCH;
                        rom_rd_q   <= 1'b1;
                        rom_addr_q <= fetch_addr;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    row_q    <= row_d;
                    x_q      <= sprite_x;
                    mirror_q <= mirror;
                    scale_q  <= scale;
                    state_q  <= ARMED;
                end
                ARMED: begin
                    if (at_load) begin
                        state_q <= CHECK;
                    end else if (at_start) begin
                        gfx_q    <= display_on & pix;
                        active_q <= 1'b1;
                        pc_q     <= PCW'(1);
                        state_q  <= (ew_last == '0) ? IDLE : DRAW;
                    end
                end
                DRAW: begin
                    if (at_load) begin
                        state_q <= CHECK;
                    end else begin
                        gfx_q    <= display_on & pix;
                        active_q <= 1'b1;
                        pc_q     <= pc_q + PCW'(1);
                        if (pc_q == ew_last) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_rd   = rom_rd_q;
    assign rom_addr = rom_addr_q;
    assign gfx      = gfx_q;
    assign active   = active_q;
endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer: directed vector table, reset-during-draw sequence,
// then randomized lines compared with a pixel-list reference model.
module tb_sprite_line_renderer;
    localparam int W    = 8;
    localparam int H    = 16;
    localparam int AW   = 4;
    localparam int LOAD = 256;
    localparam int HTOT = 340;

    typedef logic [HTOT-1:0] vec_t;
    typedef struct {
        bit en; int x; int y; bit hf; bit vf; bit mi; bit sc;
    } cfg_t;
    typedef struct {
        cfg_t c; int v; logic [W-1:0] row;
        bit exp_rd; int exp_addr; logic [31:0] exp_pat; int exp_act;
    } tv_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    hpos, vpos, sprite_x, sprite_y;
    logic          display_on, enable, hflip, vflip, mirror, scale;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_data;
    logic          gfx, active;

    logic [W-1:0]  rom [H];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            blank_lo = 0;
    int            blank_hi = 0;
    vec_t          gvec, avec, rvec;
    logic [AW-1:0] seen_addr;

    always #5 clk = ~clk;

    // Data is valid only in the cycle after the strobe; junk otherwise.
    always @(posedge clk) rom_data <= rom_rd ? rom[rom_addr] : W'($urandom);

    sprite_line_renderer #(.W(W), .H(H), .AW(AW), .LOAD_HPOS(LOAD)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .enable(enable), .sprite_x(sprite_x), .sprite_y(sprite_y), .hflip(hflip),
        .vflip(vflip), .mirror(mirror), .scale(scale), .rom_rd(rom_rd),
        .rom_addr(rom_addr), .rom_data(rom_data), .gfx(gfx), .active(active)
    );

    function automatic bit disp(input int h);
        return (h < LOAD) && !(h >= blank_lo && h < blank_hi);
    endfunction

    task automatic check(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic apply(input cfg_t c);
        enable   = c.en;
        sprite_x = 9'(c.x);
        sprite_y = 9'(c.y);
        hflip    = c.hf;
        vflip    = c.vf;
        mirror   = c.mi;
        scale    = c.sc;
    endtask

    // One full line; sample index h holds the outputs observed while hpos==h.
    task automatic run_line(input int v, input bit scramble);
        for (int h = 0; h < HTOT; h++) begin
            @(posedge clk);
            #1;
            hpos       = 9'(h);
            vpos       = 9'(v);
            display_on = disp(h);
            if (scramble && h == 0) begin
                enable   = 1'($urandom);
                sprite_x = 9'($urandom);
                sprite_y = 9'($urandom);
                hflip    = 1'($urandom);
                vflip    = 1'($urandom);
                mirror   = 1'($urandom);
                scale    = 1'($urandom);
            end
            @(negedge clk);
            gvec[h] = gfx;
            avec[h] = active;
            rvec[h] = rom_rd;
            if (rom_rd) seen_addr = rom_addr;
        end
    endtask

    // Reference: which row line v+1 needs, then the sprite as a list of pixels placed at x.
    task automatic model(input cfg_t c, input int v, output vec_t er, output int ea,
                         output vec_t eg, output vec_t eact);
        int L, dy, r;
        logic [W-1:0] row;
        bit base[$];
        bit tmp[$];
        bit pl[$];
        er = '0; eg = '0; eact = '0; ea = 0;
        L  = (v + 1) % 512;
        dy = (L - c.y + 512) % 512;
        if (!c.en || dy >= (c.sc ? 2 * H : H)) return;
        r  = c.sc ? dy / 2 : dy;
        ea = c.vf ? H - 1 - r : r;
        er[LOAD + 2] = 1'b1;
        row = rom[ea];
        for (int i = 0; i < W; i++) base.push_back(row[W-1-i]);
        if (c.hf) begin
            tmp = base;
            base.delete();
            foreach (tmp[i]) base.push_front(tmp[i]);
        end
        if (c.mi) for (int i = base.size() - 1; i >= 0; i--) base.push_back(base[i]);
        foreach (base[i]) begin
            pl.push_back(base[i]);
            if (c.sc) pl.push_back(base[i]);
        end
        if (c.x < LOAD) begin
            foreach (pl[k]) begin
                if (c.x + k < LOAD) begin
                    eact[c.x + k + 1] = 1'b1;
                    eg[c.x + k + 1]   = pl[k] & disp(c.x + k);
                end
            end
        end
    endtask

    task automatic scenario(input cfg_t c, input int v, input bit scr, input string tag);
        vec_t er, eg, eact;
        int ea;
        model(c, v, er, ea, eg, eact);
        apply(c);
        run_line(v, 1'b0);
        check({tag, "_rd"}, rvec, er);
        if (er != '0) check({tag, "_addr"}, vec_t'(seen_addr), vec_t'(ea));
        run_line((v + 1) % 512, scr);
        check({tag, "_gfx"}, gvec, eg);
        check({tag, "_active"}, avec, eact);
    endtask

    initial begin
        tv_t  tv[$];
        cfg_t c;
        vec_t er, eg, eact, mask;
        int   ea;

        reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0;
        apply('{0, 0, 0, 0, 0, 0, 0});
        for (int a = 0; a < H; a++) rom[a] = W'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_gfx", vec_t'(gfx), '0);
        check("reset_active", vec_t'(active), '0);
        check("reset_rom_rd", vec_t'(rom_rd), '0);
        check("reset_rom_addr", vec_t'(rom_addr), '0);
        reset = 1'b0;

        //                en  x   y  hf vf mi sc    v    row   rd addr pattern act
        tv.push_back('{'{1, 100, 50, 0, 0, 0, 0},  49, 8'h2E, 1,  0, 32'h74,    8});
        tv.push_back('{'{1, 100, 50, 0, 1, 0, 0},  49, 8'h2E, 1, 15, 32'h74,    8});
        tv.push_back('{'{1, 100, 50, 1, 0, 0, 0},  49, 8'h2E, 1,  0, 32'h2E,    8});
        tv.push_back('{'{1, 100, 50, 0, 0, 1, 0},  49, 8'hC0, 1,  0, 32'hC003, 16});
        tv.push_back('{'{1, 100, 50, 0, 0, 0, 1},  50, 8'h2E, 1,  0, 32'h3F30, 16});
        tv.push_back('{'{1, 100, 50, 0, 0, 0, 1},  51, 8'h80, 1,  1, 32'h3,    16});
        tv.push_back('{'{1, 100, 50, 0, 0, 0, 1},  80, 8'h01, 1, 15, 32'hC000, 16});
        tv.push_back('{'{1, 100, 50, 0, 0, 0, 1},  81, 8'hFF, 0,  0, 32'h0,     0});
        tv.push_back('{'{0, 100, 50, 0, 0, 0, 0},  49, 8'hFF, 0,  0, 32'h0,     0});
        tv.push_back('{'{1, 100, 200, 0, 0, 0, 0}, 49, 8'hFF, 0,  0, 32'h0,     0});
        tv.push_back('{'{1, 300, 50, 0, 0, 0, 0},  49, 8'hFF, 1,  0, 32'h0,     0});
        tv.push_back('{'{1, 250, 50, 0, 0, 0, 0},  49, 8'hFF, 1,  0, 32'h3F,    6});
        tv.push_back('{'{1, 10, 510, 0, 0, 0, 0}, 511, 8'h80, 1,  2, 32'h1,     8});
        tv.push_back('{'{1, 20, 50, 1, 1, 1, 1},   60, 8'h80, 1, 10, 32'h3C000, 32});

        foreach (tv[i]) begin
            for (int a = 0; a < H; a++) rom[a] = W'($urandom);
            rom[tv[i].exp_addr] = tv[i].row;
            apply(tv[i].c);
            run_line(tv[i].v, 1'b0);
            er = tv[i].exp_rd ? (vec_t'(1) << (LOAD + 2)) : '0;
            check($sformatf("vec%0d_rd", i), rvec, er);
            if (tv[i].exp_rd) check($sformatf("vec%0d_addr", i), vec_t'(seen_addr), vec_t'(tv[i].exp_addr));
            run_line((tv[i].v + 1) % 512, 1'b0);
            eg = '0;
            for (int k = 0; k < 32; k++) if (tv[i].exp_pat[k]) eg[tv[i].c.x + k + 1] = 1'b1;
            check($sformatf("vec%0d_gfx", i), gvec, eg);
            check($sformatf("vec%0d_active_cycles", i), vec_t'($countones(avec)), vec_t'(tv[i].exp_act));
        end

        // Async reset in the middle of a draw, then the following line must render normally.
        c = '{1, 100, 50, 0, 1, 0, 0};
        rom[15] = 8'h2E;
        rom[14] = 8'h96;
        apply(c);
        run_line(49, 1'b0);
        check("rstseq_addr", vec_t'(seen_addr), vec_t'(15));
        model(c, 50, er, ea, eg, eact);
        for (int h = 0; h < HTOT; h++) begin
            @(posedge clk);
            #1;
            hpos = 9'(h); vpos = 9'd50; display_on = disp(h);
            @(negedge clk);
            if (h == 103) begin
                check("pre_rst_gfx", vec_t'(gfx), vec_t'(1));
                check("pre_rst_active", vec_t'(active), vec_t'(1));
                reset = 1'b1;
                #1;
                check("rst_gfx", vec_t'(gfx), '0);
                check("rst_active", vec_t'(active), '0);
                check("rst_rom_addr", vec_t'(rom_addr), '0);
            end
            if (h == 106) reset = 1'b0;
            gvec[h] = gfx;
            rvec[h] = rom_rd;
            if (rom_rd) seen_addr = rom_addr;
        end
        mask = ~vec_t'(0) << 104;
        check("rst_line_quiet", gvec & mask, '0);
        check("post_rst_rd", rvec, er);
        check("post_rst_addr", vec_t'(seen_addr), vec_t'(ea));
        run_line(51, 1'b0);
        check("post_rst_gfx", gvec, eg);
        check("post_rst_active", avec, eact);

        for (int n = 0; n < 30; n++) begin
            int v;
            v    = $urandom_range(0, 511);
            c.en = ($urandom_range(0, 7) != 0);
            c.x  = $urandom_range(0, 299);
            c.y  = ((v + 1) - $urandom_range(0, 40) + 512) % 512;
            c.hf = 1'($urandom);
            c.vf = 1'($urandom);
            c.mi = 1'($urandom);
            c.sc = 1'($urandom);
            for (int a = 0; a < H; a++) rom[a] = W'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                blank_lo = $urandom_range(0, 255);
                blank_hi = blank_lo + $urandom_range(1, 40);
            end else begin
                blank_lo = 0;
                blank_hi = 0;
            end
            scenario(c, v, 1'($urandom), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
